// File: rtl/prbs_pattern_engine_pkg.sv
// Shared types for the PRBS pattern engine: mode and FSM encodings, LFSR length and taps.
// Optional feature macro used by the top: PRBS_ERR_CNT_EN.
package prbs_pattern_engine_pkg;

    localparam int LFSR_MAX = 23;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS9  = 2'd1,
        MODE_PRBS15 = 2'd2,
        MODE_PRBS23 = 2'd3
    } prbs_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PATTERN = 2'd1,
        ST_PRBS    = 2'd2
    } state_e;

    typedef logic [4:0] tap_t;

    // Bit positions (exponent - 1) of the two polynomial terms x^a + x^b + 1.
    function automatic tap_t tap_hi(prbs_mode_e m);
        case (m)
            MODE_PRBS7:  return 5'd6;
            MODE_PRBS9:  return 5'd8;
            MODE_PRBS15: return 5'd14;
            default:     return 5'd22;
        endcase
    endfunction

    function automatic tap_t tap_lo(prbs_mode_e m);
        case (m)
            MODE_PRBS7:  return 5'd5;
            MODE_PRBS9:  return 5'd4;
            MODE_PRBS15: return 5'd13;
            default:     return 5'd17;
        endcase
    endfunction

endpackage

// File: rtl/prbs_pattern_engine_if.sv
// Control, stream and status signals of the PRBS pattern engine.
// master = test controller / link side, slave = the engine.
interface prbs_pattern_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int REP_WIDTH  = 8
);
    logic                  Valid;
    logic [DATA_WIDTH-1:0] IN;
    logic [REP_WIDTH-1:0]  N;
    logic [1:0]            Mode;
    logic [OUT_WIDTH-1:0]  Data_out;
    logic                  Data_out_valid;
    logic [OUT_WIDTH-1:0]  Data_in;
    logic                  Data_in_valid;
    logic                  Busy;
    logic                  Done;
    logic                  pattern_correct;
    logic [15:0]           Err_count;

    modport master (
        output Valid, IN, N, Mode, Data_in, Data_in_valid,
        input  Data_out, Data_out_valid, Busy, Done, pattern_correct, Err_count
    );

    modport slave (
        input  Valid, IN, N, Mode, Data_in, Data_in_valid,
        output Data_out, Data_out_valid, Busy, Done, pattern_correct, Err_count
    );
endinterface

// File: rtl/prbs_pattern_engine_lfsr.sv
// Fibonacci LFSR (up to 23 bits) producing OUT_WIDTH feedback bits per enable, first bit in the MSB.
module prbs_pattern_engine_lfsr
    import prbs_pattern_engine_pkg::*;
#(
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 en_i,
    input  prbs_mode_e           mode_i,
    output logic [OUT_WIDTH-1:0] beat_o
);

    logic [LFSR_MAX-1:0]  state_q, state_d, stepped;
    logic [OUT_WIDTH-1:0] beat;

    // Unused upper bits of the register never reach the taps of shorter polynomials.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
        stepped = state_q;
        beat    = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            beat[OUT_WIDTH-1-i] = stepped[tap_hi(mode_i)] ^ stepped[tap_lo(mode_i)];
            stepped             = {stepped[LFSR_MAX-2:0], beat[OUT_WIDTH-1-i]};
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_i)    state_d = '1;
        else if (en_i) state_d = stepped;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= '1;
        else        state_q <= state_d;
    end

    assign beat_o = beat;

endmodule

// File: rtl/prbs_pattern_engine.sv
// Seed-word + PRBS pattern generator with an independent loopback checker.
// Define PRBS_ERR_CNT_EN to build the saturating mismatched-beat counter on Err_count.
module prbs_pattern_engine
    import prbs_pattern_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int REP_WIDTH  = 8,
    parameter int PRBS_WORDS = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    prbs_pattern_engine_if.slave bus
);

    localparam int W     = DATA_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int CNT_W = (PRBS_WORDS > 1) ? $clog2(PRBS_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRBS_WORDS - 1);

    state_e                gen_q, gen_d, chk_q, chk_d;
    logic [DATA_WIDTH-1:0] in_q;
    logic [REP_WIDTH-1:0]  n_q;
    prbs_mode_e            mode_q;
    logic [IDX_W-1:0]      gen_idx_q, gen_idx_d, chk_idx_q, chk_idx_d;
    logic [REP_WIDTH-1:0]  gen_rep_q, gen_rep_d, chk_rep_q, chk_rep_d;
    logic [CNT_W-1:0]      gen_cnt_q, gen_cnt_d, chk_cnt_q, chk_cnt_d;
    logic                  busy_q, busy_d, done_q, done_d, pc_q, pc_d, err_q, err_d;
    logic                  accept, gen_lfsr_en, chk_lfsr_en, chk_step, mismatch;
    logic [OUT_WIDTH-1:0]  gen_prbs_beat, chk_prbs_beat, chk_expect;

    // Beat idx of the seed word, counted from the most significant end.
    function automatic logic [OUT_WIDTH-1:0] seed_beat(logic [DATA_WIDTH-1:0] w, logic [IDX_W-1:0] idx);
        return OUT_WIDTH'(w >> ((W - 1 - int'(idx)) * OUT_WIDTH));
    endfunction

    assign accept     = bus.Valid & ~busy_q;
    assign chk_expect = (chk_q == ST_PATTERN) ? seed_beat(in_q, chk_idx_q) : chk_prbs_beat;
    assign chk_step   = bus.Data_in_valid & (chk_q != ST_IDLE);
    assign mismatch   = chk_step & (bus.Data_in != chk_expect);

    always_comb begin
        gen_d       = gen_q;
        gen_idx_d   = gen_idx_q;
        gen_rep_d   = gen_rep_q;
        gen_cnt_d   = gen_cnt_q;
        gen_lfsr_en = 1'b0;
        case (gen_q)
            ST_PATTERN: begin
                if (gen_idx_q == IDX_LAST) begin
                    gen_idx_d = '0;
                    if (gen_rep_q + REP_WIDTH'(1) == n_q) begin
                        gen_rep_d = '0;
                        gen_d     = ST_PRBS;
                    end else begin
                        gen_rep_d = gen_rep_q + REP_WIDTH'(1);
                    end
                end else begin
                    gen_idx_d = gen_idx_q + IDX_W'(1);
                end
            end
            ST_PRBS: begin
                gen_lfsr_en = 1'b1;
                gen_cnt_d   = gen_cnt_q + CNT_W'(1);
                if (gen_cnt_q == CNT_LAST) begin
                    gen_cnt_d = '0;
                    gen_d     = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            gen_d     = (bus.N == '0) ? ST_PRBS : ST_PATTERN;
            gen_idx_d = '0;
            gen_rep_d = '0;
            gen_cnt_d = '0;
        end
    end

    // Checker walks the same sequence, but only on beats that actually come back.
    always_comb begin
        chk_d       = chk_q;
        chk_idx_d   = chk_idx_q;
        chk_rep_d   = chk_rep_q;
        chk_cnt_d   = chk_cnt_q;
        chk_lfsr_en = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pc_d        = pc_q;
        err_d       = err_q | mismatch;
        if (chk_step) begin
            case (chk_q)
                ST_PATTERN: begin
                    if (chk_idx_q == IDX_LAST) begin
                        chk_idx_d = '0;
                        if (chk_rep_q + REP_WIDTH'(1) == n_q) begin
                            chk_rep_d = '0;
                            chk_d     = ST_PRBS;
                        end else begin
                            chk_rep_d = chk_rep_q + REP_WIDTH'(1);
                        end
                    end else begin
                        chk_idx_d = chk_idx_q + IDX_W'(1);
                    end
                end
                ST_PRBS: begin
                    chk_lfsr_en = 1'b1;
                    chk_cnt_d   = chk_cnt_q + CNT_W'(1);
                    if (chk_cnt_q == CNT_LAST) begin
                        chk_cnt_d = '0;
                        chk_d     = ST_IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pc_d      = ~(err_q | mismatch);
                    end
                end
                default: ;
            endcase
        end
        if (accept) begin
            chk_d     = (bus.N == '0) ? ST_PRBS : ST_PATTERN;
            chk_idx_d = '0;
            chk_rep_d = '0;
            chk_cnt_d = '0;
            busy_d    = 1'b1;
            pc_d      = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gen_q     <= ST_IDLE;
            chk_q     <= ST_IDLE;
            in_q      <= '0;
            n_q       <= '0;
            mode_q    <= MODE_PRBS7;
            gen_idx_q <= '0;
            gen_rep_q <= '0;
            gen_cnt_q <= '0;
            chk_idx_q <= '0;
            chk_rep_q <= '0;
            chk_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pc_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            gen_q     <= gen_d;
            chk_q     <= chk_d;
            gen_idx_q <= gen_idx_d;
            gen_rep_q <= gen_rep_d;
            gen_cnt_q <= gen_cnt_d;
            chk_idx_q <= chk_idx_d;
            chk_rep_q <= chk_rep_d;
            chk_cnt_q <= chk_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            if (accept) begin
                in_q   <= bus.IN;
                n_q    <= bus.N;
                mode_q <= prbs_mode_e'(bus.Mode);
            end
        end
    end

    prbs_pattern_engine_lfsr #(.OUT_WIDTH(OUT_WIDTH)) u_gen_lfsr (
        .clk    (CLK),
        .rst_n  (RST),
        .load_i (accept),
        .en_i   (gen_lfsr_en),
        .mode_i (mode_q),
        .beat_o (gen_prbs_beat)
    );

    prbs_pattern_engine_lfsr #(.OUT_WIDTH(OUT_WIDTH)) u_chk_lfsr (
        .clk    (CLK),
        .rst_n  (RST),
        .load_i (accept),
        .en_i   (chk_lfsr_en),
        .mode_i (mode_q),
        .beat_o (chk_prbs_beat)
    );

`ifdef PRBS_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                                  err_cnt_q <= '0;
        else if (accept)                           err_cnt_q <= '0;
        else if (mismatch && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign bus.Err_count = err_cnt_q;
`else
    assign bus.Err_count = '0;
`endif

    assign bus.Data_out_valid  = (gen_q != ST_IDLE);
    assign bus.Data_out        = (gen_q == ST_PATTERN) ? seed_beat(in_q, gen_idx_q) :
                                 (gen_q == ST_PRBS)    ? gen_prbs_beat : '0;
    assign bus.Busy            = busy_q;
    assign bus.Done            = done_q;
    assign bus.pattern_correct = pc_q;

endmodule

// File: tb/tb_prbs_pattern_engine.sv
// Self-checking bench: behavioural sequence model (bit recurrence), loopback with corruption/delay.
module tb_prbs_pattern_engine;

    localparam int DW = 32;
    localparam int OW = 8;
    localparam int RW = 8;
    localparam int PW = 16;
    localparam int W  = DW / OW;
`ifdef PRBS_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs_pattern_engine_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .REP_WIDTH(RW)) bus ();

    prbs_pattern_engine #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .REP_WIDTH  (RW),
        .PRBS_WORDS (PW)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic [OW-1:0] data;
        int            ready;
    } dly_t;

    int            checks   = 0;
    int            failures = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] dut_beats[$];
    logic [OW-1:0] corrupt[int];
    dly_t          dly_q[$];
    dly_t          dly_e;
    int            exp_len    = 0;
    int            out_idx    = 0;
    int            rx_sent    = 0;
    int            tx_idx     = 0;
    int            cyc        = 0;
    int            lb_mode    = 0;
    bit            gen_expect = 1'b0;
    bit            junk_en    = 1'b0;
    logic [OW-1:0] lb_d;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_err_of(int n);
        return ERR_EN ? ((n > 65535) ? 65535 : n) : 0;
    endfunction

    // Output bit k of a PRBS with poly x^a+x^b+1 from an all-ones start obeys b[k] = b[k-a] ^ b[k-b],
    // with every bit before the sequence start taken as 1.
    function automatic void build_model(logic [DW-1:0] seed, int n, int mode);
        int            a, b;
        bit            pb[];
        logic [OW-1:0] bt;
        case (mode)
            0:       begin a = 7;  b = 6;  end
            1:       begin a = 9;  b = 5;  end
            2:       begin a = 15; b = 14; end
            default: begin a = 23; b = 18; end
        endcase
        pb = new[PW * OW];
        for (int k = 0; k < PW * OW; k++)
            pb[k] = ((k - a < 0) ? 1'b1 : pb[k - a]) ^ ((k - b < 0) ? 1'b1 : pb[k - b]);
        exp_q.delete();
        for (int r = 0; r < n; r++)
            for (int w = 0; w < W; w++)
                exp_q.push_back(OW'(seed >> ((W - 1 - w) * OW)));
        for (int j = 0; j < PW; j++) begin
            for (int i = 0; i < OW; i++) bt[OW-1-i] = pb[j * OW + i];
            exp_q.push_back(bt);
        end
        exp_len = exp_q.size();
    endfunction

    // Compare process plus loopback path, both on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (gen_expect && out_idx < exp_len) begin
                check("dout_valid", bus.Data_out_valid, 1);
                check("dout_beat", bus.Data_out, exp_q[out_idx]);
                dut_beats.push_back(bus.Data_out);
                out_idx++;
            end else begin
                check("dout_idle_valid", bus.Data_out_valid, 0);
                check("dout_idle_zero", bus.Data_out, 0);
            end
            if (bus.Done) check("done_legal", gen_expect && rx_sent == exp_len, 1);

            bus.Data_in_valid = 1'b0;
            bus.Data_in       = OW'($urandom);
            if (gen_expect && bus.Data_out_valid) begin
                lb_d = bus.Data_out;
                if (corrupt.exists(tx_idx)) lb_d = lb_d ^ corrupt[tx_idx];
                tx_idx++;
                if (lb_mode == 0) begin
                    bus.Data_in       = lb_d;
                    bus.Data_in_valid = 1'b1;
                    rx_sent++;
                end else begin
                    dly_e.data  = lb_d;
                    dly_e.ready = cyc + 3;
                    dly_q.push_back(dly_e);
                end
            end
            if (lb_mode == 1 && cyc % 2 == 0 && dly_q.size() > 0 && dly_q[0].ready <= cyc) begin
                dly_e             = dly_q.pop_front();
                bus.Data_in       = dly_e.data;
                bus.Data_in_valid = 1'b1;
                rx_sent++;
            end
            if (!gen_expect && junk_en) bus.Data_in_valid = 1'($urandom_range(0, 1));
        end else begin
            bus.Data_in_valid = 1'b0;
        end
    end

    task automatic start_run(logic [DW-1:0] seed, int n, int mode, int lbm);
        @(negedge clk); #1;
        check("idle_before_start", bus.Busy, 0);
        build_model(seed, n, mode);
        lb_mode    = lbm;
        out_idx    = 0;
        rx_sent    = 0;
        tx_idx     = 0;
        dly_q.delete();
        dut_beats.delete();
        gen_expect = 1'b1;
        bus.Valid  = 1'b1;
        bus.IN     = seed;
        bus.N      = RW'(n);
        bus.Mode   = 2'(mode);
        @(negedge clk); #1;
        bus.Valid  = 1'b0;
        bus.IN     = $urandom;
        bus.N      = RW'($urandom);
        bus.Mode   = 2'($urandom);
        check("busy_after_accept", bus.Busy, 1);
        check("pc_cleared", bus.pattern_correct, 0);
    endtask

    task automatic wait_done(string tag, bit exp_pc, int exp_err);
        int k    = 0;
        bit seen = 1'b0;
        while (k < 3000 && !seen) begin
            @(negedge clk); #1;
            if (bus.Done) seen = 1'b1;
            k++;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_busy_low"}, bus.Busy, 0);
            check({tag, "_pattern_correct"}, bus.pattern_correct, exp_pc);
            check({tag, "_err_count"}, bus.Err_count, exp_err);
            check({tag, "_beats_sent"}, out_idx, exp_len);
            @(negedge clk); #1;
            check({tag, "_done_one_cycle"}, bus.Done, 0);
            check({tag, "_pc_hold"}, bus.pattern_correct, exp_pc);
            check({tag, "_err_hold"}, bus.Err_count, exp_err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mode, lbm, len, k;
        logic [DW-1:0] seed;

        bus.Valid = 1'b0;
        bus.IN    = '0;
        bus.N     = '0;
        bus.Mode  = '0;
        #2;
        check("rst_dout_valid", bus.Data_out_valid, 0);
        check("rst_dout", bus.Data_out, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_pc", bus.pattern_correct, 0);
        check("rst_err", bus.Err_count, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Returned beats while idle must be ignored.
        junk_en = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("idle_junk_busy", bus.Busy, 0);
        check("idle_junk_done", bus.Done, 0);
        junk_en = 1'b0;

        // Seed word twice then PRBS15, direct loopback.
        corrupt.delete();
        start_run(32'hABCD0402, 2, 2, 0);
        check("model_p15_len", exp_len, 24);
        check("model_p15_b8", exp_q[8], 8'h00);
        check("model_p15_b9", exp_q[9], 8'h02);
        wait_done("t1", 1'b1, 0);
        check("t1_nbeats", dut_beats.size(), 24);
        check("t1_beat0", dut_beats[0], 8'hAB);
        check("t1_beat1", dut_beats[1], 8'hCD);
        check("t1_beat2", dut_beats[2], 8'h04);
        check("t1_beat7", dut_beats[7], 8'h02);
        check("t1_beat8", dut_beats[8], 8'h00);
        check("t1_beat9", dut_beats[9], 8'h02);

        // One flipped bit on returned beat 5.
        corrupt.delete();
        corrupt[5] = 8'h01;
        start_run(32'hABCD0402, 2, 2, 0);
        wait_done("t2", 1'b0, exp_err_of(1));

        // No seed beats, PRBS7 only.
        corrupt.delete();
        start_run(32'hDEADBEEF, 0, 0, 0);
        check("model_p7_len", exp_len, 16);
        check("model_p7_b0", exp_q[0], 8'h02);
        check("model_p7_b1", exp_q[1], 8'h0C);
        wait_done("t3", 1'b1, 0);
        check("t3_beat0", dut_beats[0], 8'h02);
        check("t3_beat1", dut_beats[1], 8'h0C);

        // Three-cycle delayed loopback with gaps.
        start_run($urandom, 3, $urandom_range(0, 3), 1);
        wait_done("t4", 1'b1, 0);

        // Valid re-asserted while busy with different settings: must be ignored.
        start_run(32'hCAFEF00D, 1, 1, 0);
        repeat (2) @(negedge clk);
        #1;
        bus.Valid = 1'b1;
        bus.IN    = 32'h12345678;
        bus.N     = 8'd7;
        bus.Mode  = 2'd3;
        repeat (3) @(negedge clk);
        #1 bus.Valid = 1'b0;
        wait_done("t5", 1'b1, 0);

        // Reset in the middle of the PRBS phase.
        start_run(32'h0F1E2D3C, 2, 1, 0);
        k = 0;
        while (out_idx <= 2 * W + 3 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("t5_reached_prbs", out_idx > 2 * W + 3, 1);
        rst_n = 1'b0;
        #1;
        check("abort_dout_valid", bus.Data_out_valid, 0);
        check("abort_dout", bus.Data_out, 0);
        check("abort_busy", bus.Busy, 0);
        check("abort_done", bus.Done, 0);
        check("abort_pc", bus.pattern_correct, 0);
        check("abort_err", bus.Err_count, 0);
        gen_expect = 1'b0;
        dly_q.delete();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_abort_done", bus.Done, 0);
        check("post_abort_busy", bus.Busy, 0);

        // PRBS23 with three corrupted PRBS beats.
        corrupt.delete();
        corrupt[6]  = 8'h80;
        corrupt[10] = 8'h3C;
        corrupt[19] = 8'h01;
        start_run(32'h5A5AA5A5, 1, 3, 0);
        wait_done("t6", 1'b0, exp_err_of(3));

        // Randomized runs.
        for (int it = 0; it < 8; it++) begin
            n    = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            lbm  = $urandom_range(0, 1);
            seed = $urandom;
            len  = n * W + PW;
            corrupt.delete();
            for (int c = 0; c < int'($urandom_range(0, 2)); c++)
                corrupt[$urandom_range(0, len - 1)] = OW'($urandom_range(1, 255));
            start_run(seed, n, mode, lbm);
            wait_done("rand", corrupt.num() == 0, exp_err_of(corrupt.num()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
